// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative 32-cycle multiply/divide into
// HI/LO, and the registered EX/MEM latch with a stall back to decode.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] imm,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  aluop,
  input  logic        alusrc,
  input  logic        regwrite_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic [4:0]  rd_out,
  output logic        regwrite_out,
  output logic        memread_out,
  output logic        memwrite_out,
  output logic        zero
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MD_CYCLES = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;
  localparam logic [4:0] OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd16;
  localparam logic [4:0] OP_MFLO = 5'd17;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic               r_stall;

  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;

  // Iteration state for the multiply/divide unit
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dvz;
  logic [XLEN-1:0]    r_dividend;
  logic [2*XLEN-1:0]  r_acc;
  logic [2*XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_divisor;

  // EX/MEM latch
  logic               r_valid;
  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    r_store;
  logic [4:0]         r_rd;
  logic               r_regwrite;
  logic               r_memread;
  logic               r_memwrite;
  logic               r_zero;

  logic               w_accept;
  logic               w_load;
  logic               w_md_op;
  logic               w_md_start;
  logic               w_md_done;
  logic [XLEN-1:0]    w_x;
  logic [4:0]         w_shamt;
  logic [XLEN-1:0]    w_alu;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_x_neg;
  logic [XLEN-1:0]    w_a_mag;
  logic [XLEN-1:0]    w_x_mag;

  logic [2*XLEN-1:0]  w_acc_nxt;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN:0]      w_shift;
  logic               w_ge;
  logic [XLEN-1:0]    w_sub;
  logic [XLEN-1:0]    w_rem_nxt;
  logic [XLEN-1:0]    w_quo_nxt;
  logic [XLEN-1:0]    w_q_fin;
  logic [XLEN-1:0]    w_r_fin;
  logic [XLEN-1:0]    w_hi_fin;
  logic [XLEN-1:0]    w_lo_fin;

  assign w_accept   = valid_in & ~r_stall;
  assign w_load     = w_accept & ~flush;
  assign w_md_op    = (aluop[4:2] == 3'b011);
  assign w_md_start = w_load & w_md_op & (r_state == ST_IDLE);
  assign w_md_done  = (r_state == ST_RUN) && (r_count == CNT_W'(MD_CYCLES - 1));

  assign w_x     = alusrc ? imm : B;
  assign w_shamt = alusrc ? imm[10:6] : A[4:0];

  // Single-cycle ALU result select
  always_comb begin
    w_alu = '0;
    case (aluop)
      OP_ADD:  w_alu = A + w_x;
      OP_SUB:  w_alu = A - w_x;
      OP_AND:  w_alu = A & w_x;
      OP_OR:   w_alu = A | w_x;
      OP_XOR:  w_alu = A ^ w_x;
      OP_NOR:  w_alu = ~(A | w_x);
      OP_SLT:  w_alu = {31'b0, ($signed(A) < $signed(w_x))};
      OP_SLTU: w_alu = {31'b0, (A < w_x)};
      OP_SLL:  w_alu = B << w_shamt;
      OP_SRL:  w_alu = B >> w_shamt;
      OP_SRA:  w_alu = XLEN'($signed(B) >>> w_shamt);
      OP_LUI:  w_alu = {imm[15:0], 16'h0000};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Operand magnitudes for the iterative unit; odd opcodes are unsigned
  assign w_signed = ~aluop[0];
  assign w_a_neg  = w_signed & A[31];
  assign w_x_neg  = w_signed & w_x[31];
  assign w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
  assign w_x_mag  = w_x_neg ? (~w_x + 32'd1) : w_x;

  // One shift-add step and one restoring-divide step per RUN cycle
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_divisor});
  assign w_sub     = w_shift[XLEN-1:0] - r_divisor;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  // Sign fix-up applied on the final iteration
  assign w_prod  = r_neg_res ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  assign w_q_fin = r_neg_res ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
  assign w_r_fin = r_neg_rem ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  // Final HI/LO selection, including the divide-by-zero convention
  always_comb begin
    w_hi_fin = w_prod[2*XLEN-1:XLEN];
    w_lo_fin = w_prod[XLEN-1:0];
    if (r_is_div) begin
      if (r_dvz) begin
        w_hi_fin = r_dividend;
        w_lo_fin = '1;
      end else begin
        w_hi_fin = w_r_fin;
        w_lo_fin = w_q_fin;
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_md_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_md_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, iteration counter and registered stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_state_nxt == ST_RUN);
      if (r_state == ST_RUN && !w_md_done) r_count <= r_count + CNT_W'(1);
      else                                 r_count <= '0;
    end
  end

  // Multiply/divide datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dvz      <= 1'b0;
      r_dividend <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
    end else if (w_md_start) begin
      r_is_div   <= aluop[1];
      r_neg_res  <= w_a_neg ^ w_x_neg;
      r_neg_rem  <= w_a_neg;
      r_dvz      <= (w_x == '0);
      r_dividend <= A;
      r_acc      <= '0;
      r_mcand    <= {32'b0, w_a_mag};
      r_mplier   <= w_x_mag;
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_divisor  <= w_x_mag;
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      if (w_md_done) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
      end
    end
  end

  // EX/MEM latch; mult/div retires immediately without a register write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_store    <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_result   <= w_alu;
      r_store    <= B;
      r_rd       <= rd_in;
      r_regwrite <= regwrite_in & ~w_md_op;
      r_memread  <= memread_in;
      r_memwrite <= memwrite_in;
      r_zero     <= (w_alu == '0);
    end else begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end
  end

  assign stall_out    = r_stall;
  assign valid_out    = r_valid;
  assign result       = r_result;
  assign store_data   = r_store;
  assign rd_out       = r_rd;
  assign regwrite_out = r_regwrite;
  assign memread_out  = r_memread;
  assign memwrite_out = r_memwrite;
  assign zero         = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] imm;
  logic [4:0]  rd_in;
  logic [4:0]  aluop;
  logic        alusrc;
  logic        regwrite_in;
  logic        memread_in;
  logic        memwrite_in;
  logic        flush;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] result;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        regwrite_out;
  logic        memread_out;
  logic        memwrite_out;
  logic        zero;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .A(A), .B(B), .imm(imm),
    .rd_in(rd_in), .aluop(aluop), .alusrc(alusrc), .regwrite_in(regwrite_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in), .flush(flush),
    .stall_out(stall_out), .valid_out(valid_out), .result(result),
    .store_data(store_data), .rd_out(rd_out), .regwrite_out(regwrite_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one instruction on the ID/EX inputs
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src, input logic [4:0] rd,
                       input logic rw, input logic fl);
    valid_in    = 1'b1;
    aluop       = op;
    A           = a;
    B           = b;
    imm         = im;
    alusrc      = src;
    rd_in       = rd;
    regwrite_in = rw;
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    flush       = fl;
  endtask

  task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] im, input logic src,
                     input logic [31:0] exp);
    @(negedge clk);
    drive(op, a, b, im, src, 5'd1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check(tag, result, exp);
  endtask

  // Issue a mult/div, hold MFHI behind it, then read HI and LO
  task automatic md(input string tag, input logic [4:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n_stall;
    int pulses;
    @(negedge clk);
    drive(op, a, b, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    check({tag, "_issue_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_issue_regwrite"}, 32'(regwrite_out), 32'd0);
    n_stall = stall_out ? 1 : 0;
    pulses  = valid_out ? 1 : 0;
    @(negedge clk);
    drive(5'd16, 32'd0, 32'd0, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    for (int i = 0; i < 64 && stall_out; i++) begin
      @(posedge clk); #1;
      if (stall_out) n_stall++;
      if (valid_out) pulses++;
    end
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'd32);
    check({tag, "_valid_pulses"}, 32'(pulses), 32'd1);
    @(posedge clk); #1;
    check({tag, "_mfhi_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_hi"}, result, exp_hi);
    @(negedge clk);
    drive(5'd17, 32'd0, 32'd0, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    @(posedge clk); #1;
    check({tag, "_lo"}, result, exp_lo);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with full latch check
    @(negedge clk);
    drive(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_result", result, 32'd12);
    check("add_rd", 32'(rd_out), 32'd3);
    check("add_regwrite", 32'(regwrite_out), 32'd1);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_zero", 32'(zero), 32'd0);
    check("add_store", store_data, 32'd7);

    alu("sub", 5'd1, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFE);
    alu("slt", 5'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd1);
    alu("sltu", 5'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0);
    check("sltu_zero", 32'(zero), 32'd1);
    alu("nor", 5'd5, 32'h0F0F0000, 32'h000000F0, 32'd0, 1'b0, 32'hF0F0FF0F);
    alu("sra", 5'd10, 32'd4, 32'h80000000, 32'd0, 1'b0, 32'hF8000000);
    alu("sll_imm", 5'd8, 32'd0, 32'd1, 32'h00000100, 1'b1, 32'd16);
    alu("lui", 5'd11, 32'd0, 32'd0, 32'h00001234, 1'b1, 32'h12340000);
    alu("op_hi", 5'd20, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0);

    // Flushed ADD becomes a bubble
    @(negedge clk);
    drive(5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_regwrite", 32'(regwrite_out), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    valid_in = 1'b0;

    md("mult", 5'd12, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md("div", 5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("divu0", 5'd15, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    md("multu", 5'd13, 32'h80000000, 32'd4, 32'd2, 32'd0);

    // Asynchronous reset in the middle of a MULTU
    @(negedge clk);
    drive(5'd13, 32'd5, 32'd6, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("rstmid_store_pre", store_data, 32'd6);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("rstmid_stall_pre", 32'(stall_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall_out), 32'd0);
    check("rstmid_store", store_data, 32'd0);
    check("rstmid_rd", 32'(rd_out), 32'd0);
    check("rstmid_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    alu("rstmid_mflo", 5'd17, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    alu("rstmid_mfhi", 5'd16, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
